// File: rtl/phy_tx_pkg.sv
// Shared constants for the serial PHY transmit lane: FSM encoding,
// default training/idle symbols and the scrambler LFSR definition.
package phy_tx_pkg;

    localparam logic [1:0] ST_RST    = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    localparam logic [7:0] COM_DEF = 8'hBC;
    localparam logic [7:0] IDL_DEF = 8'h7C;

    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hFFFF;

endpackage

// File: rtl/phy_tx_scrambler.sv
// Galois LFSR data scrambler. Data is XORed with the post-step LFSR value,
// so the first scrambled word already uses the seed advanced once.
module phy_tx_scrambler
    import phy_tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [15:0]      lfsr
);

    logic [15:0] lfsr_next;

    always_comb begin
        lfsr_next = lfsr >> 1;
        if (lfsr[0]) lfsr_next = lfsr_next ^ LFSR_POLY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       lfsr <= LFSR_SEED;
        else if (step) lfsr <= lfsr_next;
    end

    assign dout = din ^ lfsr_next[WIDTH-1:0];

endmodule

// File: rtl/phy_tx_serial_lanes.sv
// Round-robin multi-channel serial transmitter: COM sync after reset, then
// per-channel word slots filled with IDLE when empty. Optional data
// scrambling is enabled by defining PHY_TX_SCRAMBLE_EN.
module phy_tx_serial_lanes
    import phy_tx_pkg::*;
#(
    parameter int                NUM_CH     = 4,
    parameter int                WIDTH      = 8,
    parameter int                SYNC_WORDS = 4,
    parameter logic [WIDTH-1:0]  COM_SYM    = WIDTH'(COM_DEF),
    parameter logic [WIDTH-1:0]  IDL_SYM    = WIDTH'(IDL_DEF),
    localparam int               CW         = $clog2(NUM_CH)
) (
    input  logic                    clk_32f,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    output logic                    data_out,
    output logic                    word_start,
    output logic                    active,
    output logic                    idle_out,
    output logic [CW-1:0]           ch_cur
);

    localparam int BCW = $clog2(WIDTH);
    localparam int SCW = $clog2(SYNC_WORDS + 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] sreg;
    logic [BCW-1:0]   bit_cnt;
    logic [SCW-1:0]   sync_cnt;
    logic [CW-1:0]    ch_ptr;
    logic             idle_flag;

    logic             last_bit, data_load, com_load, slot_valid;
    logic [WIDTH-1:0] slot_data, scr_data, next_word;

    assign last_bit   = bit_cnt == BCW'(WIDTH - 1);
    // The first data slot is loaded while still in SYNC, on the edge after the last COM word.
    assign data_load  = last_bit && (state == ST_ACTIVE ||
                        (state == ST_SYNC && sync_cnt == SCW'(SYNC_WORDS)));
    assign com_load   = (state == ST_RST) || (state == ST_SYNC && last_bit && !data_load);
    assign slot_valid = in_valid[ch_ptr];
    assign slot_data  = in_data[ch_ptr*WIDTH +: WIDTH];

`ifdef PHY_TX_SCRAMBLE_EN
    logic [15:0] lfsr;

    phy_tx_scrambler #(.WIDTH(WIDTH)) u_scr (
        .clk  (clk_32f),
        .rst  (reset),
        .step (data_load),
        .din  (slot_data),
        .dout (scr_data),
        .lfsr (lfsr)
    );
`else
    assign scr_data = slot_data;
`endif

    assign next_word = slot_valid ? scr_data : IDL_SYM;

    always_comb begin
        in_ready = '0;
        if (data_load && slot_valid) in_ready[ch_ptr] = 1'b1;
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state     <= ST_RST;
            sreg      <= '0;
            bit_cnt   <= '0;
            sync_cnt  <= '0;
            ch_ptr    <= '0;
            ch_cur    <= '0;
            idle_flag <= 1'b0;
        end else if (com_load) begin
            state     <= ST_SYNC;
            sreg      <= COM_SYM;
            bit_cnt   <= '0;
            sync_cnt  <= sync_cnt + 1'b1;
            idle_flag <= 1'b0;
        end else if (data_load) begin
            state     <= ST_ACTIVE;
            sreg      <= next_word;
            bit_cnt   <= '0;
            idle_flag <= !slot_valid;
            ch_cur    <= ch_ptr;
            ch_ptr    <= (ch_ptr == CW'(NUM_CH - 1)) ? '0 : ch_ptr + 1'b1;
        end else begin
            sreg      <= sreg << 1;
            bit_cnt   <= bit_cnt + 1'b1;
        end
    end

    assign data_out   = sreg[WIDTH-1];
    assign word_start = (state != ST_RST) && (bit_cnt == '0);
    assign active     = state == ST_ACTIVE;
    assign idle_out   = idle_flag;

endmodule

// File: tb/tb_phy_tx_serial_lanes.sv
// Scoreboard bench: stimulus pushes expected serial words, a monitor
// deserialises data_out at each word_start and compares in order.
module tb_phy_tx_serial_lanes;

    logic        clk_32f = 1'b0;
    logic        reset;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        data_out, word_start, active, idle_out;
    logic [1:0]  ch_cur;

    phy_tx_serial_lanes dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .word_start(word_start),
        .active    (active),
        .idle_out  (idle_out),
        .ch_cur    (ch_cur)
    );

    always #5 clk_32f = ~clk_32f;

    typedef struct {
        logic [7:0] d;
        logic       idle;
        logic       act;
        logic [1:0] ch;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic idle, input logic act, input logic [1:0] ch);
        exp_t e;
        e.d = d; e.idle = idle; e.act = act; e.ch = ch;
        q.push_back(e);
    endtask

    task automatic push_sync();
        for (int i = 0; i < 4; i++) push(8'hBC, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(negedge clk_32f);
            n++;
        end
        check({name, "_drain"}, q.size(), 0);
        q.delete();
    endtask

    // Monitor: deserialise one word per word_start, compare with queue head.
    initial begin
        logic [7:0] w;
        logic       s_idle, s_act, busy;
        logic [1:0] s_ch;
        int         nb;
        exp_t       e;
        busy = 1'b0; nb = 0; w = '0; s_idle = 0; s_act = 0; s_ch = 0;
        forever begin
            @(negedge clk_32f);
            if (reset) begin
                busy = 1'b0;
            end else begin
                if (word_start) begin
                    busy = 1'b1; nb = 0; w = '0;
                    s_idle = idle_out; s_act = active; s_ch = ch_cur;
                end
                if (busy) begin
                    w = {w[6:0], data_out};
                    nb++;
                    if (nb == 8) begin
                        busy = 1'b0;
                        if (q.size() != 0) begin
                            e = q.pop_front();
                            check("word", w, e.d);
                            check("idle", s_idle, e.idle);
                            check("active", s_act, e.act);
                            if (e.act) check("ch_cur", s_ch, e.ch);
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic seen;
        reset = 1'b1; in_valid = '0; in_data = '0;
        repeat (3) @(negedge clk_32f);
        check("rst_data_out", data_out, 0);
        check("rst_word_start", word_start, 0);
        check("rst_active", active, 0);
        check("rst_idle", idle_out, 0);
        check("rst_ch_cur", ch_cur, 0);
        check("rst_in_ready", in_ready, 0);

        // All idle: 4 COM then IDLE stream
        push_sync();
        for (int i = 0; i < 6; i++) push(8'h7C, 1'b1, 1'b1, 2'(i));
        reset = 1'b0;
        drain("all_idle");

        // All valid: in_ready timing and data order
        @(negedge clk_32f); reset = 1'b1;
        in_valid = 4'b1111; in_data = 32'h44332211;
        push_sync();
        push(8'h11, 0, 1, 0); push(8'h22, 0, 1, 1); push(8'h33, 0, 1, 2);
        push(8'h44, 0, 1, 3); push(8'h11, 0, 1, 0); push(8'h22, 0, 1, 1);
        @(negedge clk_32f); reset = 1'b0;
        repeat (32) @(posedge clk_32f);
        @(negedge clk_32f);
        check("ready_pre33", in_ready, 4'b0001);
        @(negedge clk_32f);
        check("ready_post33", in_ready, 4'b0000);
        repeat (7) @(negedge clk_32f);
        check("ready_pre41", in_ready, 4'b0010);
        drain("all_valid");

        // Only channel 2 valid
        @(negedge clk_32f); reset = 1'b1;
        in_valid = 4'b0100; in_data = 32'h00A50000;
        push_sync();
        for (int i = 0; i < 8; i++)
            push((i % 4 == 2) ? 8'hA5 : 8'h7C, (i % 4 != 2), 1'b1, 2'(i));
        @(negedge clk_32f); reset = 1'b0;
        drain("ch2_only");

        // Channel 1 valid mid-slot, dropped after its pulse
        @(negedge clk_32f); reset = 1'b1;
        in_valid = 4'b0000; in_data = 32'h00005A00;
        push_sync();
        push(8'h7C, 1, 1, 0); push(8'h5A, 0, 1, 1); push(8'h7C, 1, 1, 2);
        push(8'h7C, 1, 1, 3); push(8'h7C, 1, 1, 0); push(8'h7C, 1, 1, 1);
        @(negedge clk_32f); reset = 1'b0;
        repeat (35) @(posedge clk_32f);
        @(negedge clk_32f); in_valid = 4'b0010;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk_32f);
            if (in_ready[1]) seen = 1'b1;
        end
        check("ch1_ready_seen", seen, 1);
        @(posedge clk_32f); #1 in_valid = 4'b0000;
        drain("ch1_once");

        // Reset mid data word
        @(negedge clk_32f); reset = 1'b1;
        in_valid = 4'b1111; in_data = 32'h44332211;
        @(negedge clk_32f); reset = 1'b0;
        repeat (36) @(posedge clk_32f);
        #1 reset = 1'b1;
        #1;
        check("midrst_data_out", data_out, 0);
        check("midrst_active", active, 0);
        check("midrst_word_start", word_start, 0);
        check("midrst_ready", in_ready, 0);
        push_sync();
        push(8'h11, 0, 1, 0); push(8'h22, 0, 1, 1); push(8'h33, 0, 1, 2); push(8'h44, 0, 1, 3);
        @(negedge clk_32f); reset = 1'b0;
        drain("mid_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
